// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, types and GF(2^8) helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int         NUM_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;

  // 128-bit key/state word, FIPS-197 column order (w0 in the top 32 bits)
  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_READY  = 2'd1,
    KS_EXPAND = 2'd2,
    KS_FINAL  = 2'd3
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (GF inverse + affine map).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x;
    x = gf_mul(a, a);   // ^2
    x = gf_mul(x, a);   // ^3
    x = gf_mul(x, x);   // ^6
    x = gf_mul(x, a);   // ^7
    x = gf_mul(x, x);   // ^14
    x = gf_mul(x, a);   // ^15
    x = gf_mul(x, x);   // ^30
    x = gf_mul(x, a);   // ^31
    x = gf_mul(x, x);   // ^62
    x = gf_mul(x, a);   // ^63
    x = gf_mul(x, x);   // ^126
    x = gf_mul(x, a);   // ^127
    x = gf_mul(x, x);   // ^254
    return x;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_seq
// Description : On-the-fly AES-128 round-key generator with shared S-boxes.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 2,
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         load,
  input  logic         next_key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic [127:0] last_key,
  output logic         last_valid,
  output logic         sched_err
);

  localparam int         c_lat       = 4 / SBOX_LANES;
  localparam logic [1:0] c_lane_last = 2'(c_lat - 1);
  localparam logic [3:0] c_last_idx  = 4'(NUM_ROUNDS);

  ks_state_e       r_state, w_next_state;
  aes_block_t      r_round_key, r_last_key;
  logic [3:0]      r_round_idx;
  logic            r_key_valid, r_last_valid, r_sched_err;
  logic [7:0]      r_rcon;
  logic [1:0]      r_lane_cnt;
  logic [3:0][7:0] r_sub, w_sub_next, w_rot;
  logic [7:0]      w_sb_out   [SBOX_LANES];
  logic [1:0]      w_lane_idx [SBOX_LANES];
  logic            w_start, w_commit, w_set_err, w_final;
  logic [31:0]     w_s, w_w0, w_w1, w_w2, w_w3;

  // RotWord(w3); index 3 holds the most significant byte
  assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign w_lane_idx[j] = 2'(int'(r_lane_cnt) * SBOX_LANES + j);
    aes_sbox u_sbox (
      .i_byte (w_rot[~w_lane_idx[j]]),
      .o_byte (w_sb_out[j])
    );
  end

  always_comb begin
    w_sub_next = r_sub;
    for (int j = 0; j < SBOX_LANES; j++) begin
      w_sub_next[~w_lane_idx[j]] = w_sb_out[j];
    end
  end

  assign w_s     = w_sub_next ^ {r_rcon, 24'h000000};
  assign w_w0    = r_round_key[127:96] ^ w_s;
  assign w_w1    = r_round_key[95:64]  ^ w_w0;
  assign w_w2    = r_round_key[63:32]  ^ w_w1;
  assign w_w3    = r_round_key[31:0]   ^ w_w2;
  assign w_final = ((r_round_idx + 4'd1) == c_last_idx);

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_commit     = 1'b0;
    w_set_err    = 1'b0;
    if (load) begin
      w_next_state = KS_READY;
    end else begin
      case (r_state)
        KS_READY: begin
          if (next_key) begin
            w_start      = 1'b1;
            w_next_state = KS_EXPAND;
          end
        end
        KS_EXPAND: begin
          w_set_err = next_key;
          if (r_lane_cnt == c_lane_last) begin
            w_commit     = 1'b1;
            w_next_state = w_final ? KS_FINAL : KS_READY;
          end
        end
        default: w_set_err = next_key;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= KS_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_round_key  <= '0;
      r_round_idx  <= 4'd0;
      r_key_valid  <= 1'b0;
      r_last_key   <= '0;
      r_last_valid <= 1'b0;
      r_sched_err  <= 1'b0;
      r_rcon       <= RCON_INIT;
      r_lane_cnt   <= 2'd0;
      r_sub        <= '0;
    end else if (load) begin
      r_round_key  <= key_in;
      r_round_idx  <= 4'd0;
      r_rcon       <= RCON_INIT;
      r_key_valid  <= 1'b1;
      r_last_valid <= 1'b0;
      r_sched_err  <= 1'b0;
      r_lane_cnt   <= 2'd0;
    end else begin
      if (w_set_err) r_sched_err <= 1'b1;
      if (w_start) begin
        r_key_valid <= 1'b0;
        r_lane_cnt  <= 2'd0;
      end
      if (r_state == KS_EXPAND) begin
        r_sub      <= w_sub_next;
        r_lane_cnt <= r_lane_cnt + 2'd1;
      end
      if (w_commit) begin
        r_round_key <= {w_w0, w_w1, w_w2, w_w3};
        r_round_idx <= r_round_idx + 4'd1;
        r_rcon      <= xtime(r_rcon);
        r_key_valid <= 1'b1;
        if (w_final) begin
          r_last_key   <= {w_w0, w_w1, w_w2, w_w3};
          r_last_valid <= 1'b1;
        end
      end
    end
  end

  assign round_key  = r_round_key;
  assign round_idx  = r_round_idx;
  assign key_valid  = r_key_valid;
  assign last_key   = r_last_key;
  assign last_valid = r_last_valid;
  assign sched_err  = r_sched_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule_seq
// Description : Directed self-checking bench for aes_key_schedule_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_seq;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         load;
  logic         next_key;

  // index 0: SBOX_LANES=2, 1: SBOX_LANES=1, 2: SBOX_LANES=4
  logic [127:0] rk   [3];
  logic [127:0] lk   [3];
  logic [3:0]   ridx [3];
  logic         kv   [3];
  logic         lv   [3];
  logic         err  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  aes_key_schedule_seq #(.SBOX_LANES(2)) u_dut2 (
    .clock(clock), .reset(reset), .key_in(key_in), .load(load), .next_key(next_key),
    .round_key(rk[0]), .round_idx(ridx[0]), .key_valid(kv[0]),
    .last_key(lk[0]), .last_valid(lv[0]), .sched_err(err[0]));

  aes_key_schedule_seq #(.SBOX_LANES(1)) u_dut1 (
    .clock(clock), .reset(reset), .key_in(key_in), .load(load), .next_key(next_key),
    .round_key(rk[1]), .round_idx(ridx[1]), .key_valid(kv[1]),
    .last_key(lk[1]), .last_valid(lv[1]), .sched_err(err[1]));

  aes_key_schedule_seq #(.SBOX_LANES(4)) u_dut4 (
    .clock(clock), .reset(reset), .key_in(key_in), .load(load), .next_key(next_key),
    .round_key(rk[2]), .round_idx(ridx[2]), .key_valid(kv[2]),
    .last_key(lk[2]), .last_valid(lv[2]), .sched_err(err[2]));

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t         vecs    [3];
  logic [127:0] fips_rk [11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [127:0] k);
    key_in = k;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic pulse_next();
    next_key = 1'b1;
    tick();
    next_key = 1'b0;
  endtask

  task automatic wait_valid(output int gap);
    gap = 0;
    while (!kv[0] && gap < 32) begin
      gap++;
      tick();
    end
    chk("key_valid_timeout", 128'(kv[0]), 128'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_round_key"},  rk[0],          128'd0);
    chk({tag, "_round_idx"},  128'(ridx[0]),  128'd0);
    chk({tag, "_key_valid"},  128'(kv[0]),    128'd0);
    chk({tag, "_last_key"},   lk[0],          128'd0);
    chk({tag, "_last_valid"}, 128'(lv[0]),    128'd0);
    chk({tag, "_sched_err"},  128'(err[0]),   128'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int gap;
    int g [3];
    int n;

    fips_rk[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    fips_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fips_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fips_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fips_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fips_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fips_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fips_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fips_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fips_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fips_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    vecs[0] = '{key: 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                rk1: 128'ha0fafe17_88542cb1_23a33939_2a6c7605,
                rk10: 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    vecs[1] = '{key: 128'h0,
                rk1: 128'h62636363_62636363_62636363_62636363,
                rk10: 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e};
    vecs[2] = '{key: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                rk1: 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe,
                rk10: 128'h13111d7f_e3944a17_f307a78b_4d2b30c5};

    reset    = 1'b0;
    key_in   = '0;
    load     = 1'b0;
    next_key = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b1;
    tick();

    // next_key with no key loaded
    pulse_next();
    chk("idle_next_err", 128'(err[0]), 128'd1);
    chk("idle_next_idx", 128'(ridx[0]), 128'd0);

    do_load(fips_rk[0]);
    chk("load_round_key", rk[0], fips_rk[0]);
    chk("load_round_idx", 128'(ridx[0]), 128'd0);
    chk("load_key_valid", 128'(kv[0]), 128'd1);
    chk("load_sched_err", 128'(err[0]), 128'd0);

    pulse_next();
    wait_valid(gap);
    chk("r1_gap", 128'(gap), 128'd2);
    chk("r1_round_key", rk[0], fips_rk[1]);
    chk("r1_round_idx", 128'(ridx[0]), 128'd1);

    for (int r = 2; r <= 10; r++) begin
      pulse_next();
      tick();
      tick();
      tick();
      chk($sformatf("sched_r%0d_key", r), rk[0], fips_rk[r]);
      chk($sformatf("sched_r%0d_idx", r), 128'(ridx[0]), 128'(r));
    end
    chk("final_last_key", lk[0], fips_rk[10]);
    chk("final_last_valid", 128'(lv[0]), 128'd1);
    chk("final_key_valid", 128'(kv[0]), 128'd1);

    // 11th request is illegal and must not disturb the final key
    pulse_next();
    tick();
    chk("r11_sched_err", 128'(err[0]), 128'd1);
    chk("r11_round_key", rk[0], fips_rk[10]);
    chk("r11_round_idx", 128'(ridx[0]), 128'd10);

    // next_key during EXPAND: flagged, in-flight result still correct
    do_load(fips_rk[0]);
    pulse_next();
    pulse_next();
    wait_valid(gap);
    chk("exp_next_err", 128'(err[0]), 128'd1);
    chk("exp_next_key", rk[0], fips_rk[1]);
    chk("exp_next_idx", 128'(ridx[0]), 128'd1);

    // load wins over a simultaneous next_key
    key_in   = fips_rk[0];
    load     = 1'b1;
    next_key = 1'b1;
    tick();
    load     = 1'b0;
    next_key = 1'b0;
    chk("ldnext_idx", 128'(ridx[0]), 128'd0);
    chk("ldnext_err", 128'(err[0]), 128'd0);
    chk("ldnext_kv", 128'(kv[0]), 128'd1);
    tick();
    tick();
    tick();
    chk("ldnext_idx_hold", 128'(ridx[0]), 128'd0);
    chk("ldnext_key_hold", rk[0], fips_rk[0]);

    // asynchronous reset during round-3 expansion
    pulse_next();
    wait_valid(gap);
    pulse_next();
    wait_valid(gap);
    chk("pre_rst_idx", 128'(ridx[0]), 128'd2);
    pulse_next();
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    tick();
    reset = 1'b1;
    tick();
    do_load(fips_rk[0]);
    pulse_next();
    wait_valid(gap);
    chk("post_rst_r1_key", rk[0], fips_rk[1]);
    chk("post_rst_r1_idx", 128'(ridx[0]), 128'd1);

    // table-driven full schedules
    for (int v = 0; v < 3; v++) begin
      do_load(vecs[v].key);
      chk($sformatf("vec%0d_rk0", v), rk[0], vecs[v].key);
      for (int r = 1; r <= 10; r++) begin
        pulse_next();
        wait_valid(gap);
        if (r == 1) chk($sformatf("vec%0d_rk1", v), rk[0], vecs[v].rk1);
      end
      chk($sformatf("vec%0d_rk10", v), rk[0], vecs[v].rk10);
      chk($sformatf("vec%0d_last_key", v), lk[0], vecs[v].rk10);
      chk($sformatf("vec%0d_idx", v), 128'(ridx[0]), 128'd10);
    end

    // all lane widths side by side
    do_load(fips_rk[0]);
    for (int r = 1; r <= 10; r++) begin
      pulse_next();
      g = '{0, 0, 0};
      n = 0;
      while (!(kv[0] && kv[1] && kv[2]) && n < 32) begin
        for (int d = 0; d < 3; d++) if (!kv[d]) g[d]++;
        n++;
        tick();
      end
      chk($sformatf("lanes_r%0d_all_valid", r), 128'(kv[0] && kv[1] && kv[2]), 128'd1);
      if (r == 1) begin
        chk("lanes2_gap", 128'(g[0]), 128'd2);
        chk("lanes1_gap", 128'(g[1]), 128'd4);
        chk("lanes4_gap", 128'(g[2]), 128'd1);
        chk("lanes1_rk1", rk[1], fips_rk[1]);
        chk("lanes4_rk1", rk[2], fips_rk[1]);
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("lanes_dut%0d_rk10", d), rk[d], fips_rk[10]);
      chk($sformatf("lanes_dut%0d_last_key", d), lk[d], fips_rk[10]);
      chk($sformatf("lanes_dut%0d_last_valid", d), 128'(lv[d]), 128'd1);
      chk($sformatf("lanes_dut%0d_err", d), 128'(err[d]), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
